// File: rtl/pcm_bank_router.sv
`default_nettype none
// ============================================================================
// Module   : pcm_bank_router
// Brief    : Routes byte-wide PCM ROM reads to N SDRAM sample banks through a
//            registered request/ack FSM with a one-entry cache and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_bank_router #(
    parameter int NBANK   = 3,
    parameter int AW      = 24,
    parameter int BANK_AW = 22,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     REQ_RD,
    input  logic [AW-1:0]            REQ_ADDR,
    output logic [DW-1:0]            REQ_DOUT,
    output logic                     REQ_VALID,
    output logic                     BUSY,
    output logic                     ERR,
    output logic [NBANK-1:0]         BANK_CS,
    output logic [NBANK*BANK_AW-1:0] BANK_ADDR,
    input  logic [NBANK-1:0]         BANK_OK,
    input  logic [NBANK*DW-1:0]      BANK_DOUT
);

    localparam int c_IW = AW - BANK_AW;
    localparam int c_SW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int c_CW = $clog2(TIMEOUT + 1);

    localparam logic [31:0]     c_NBANK    = 32'(NBANK);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_SW-1:0] r_sel;
    logic [c_CW-1:0] r_cnt;
    logic [AW-1:0]   r_req_addr;
    logic [AW-1:0]   r_cache_addr;
    logic [DW-1:0]   r_cache_data;
    logic            r_cache_vld;
    logic [DW-1:0]   r_dout;
    logic            r_err;

    logic [c_IW-1:0] w_idx;
    logic [c_SW-1:0] w_sel;
    logic            w_hit;
    logic            w_oor;
    logic            w_load;
    logic            w_ok;
    logic            w_timeout;
    logic [DW-1:0]   w_bank_data;

    assign w_idx       = REQ_ADDR[AW-1:BANK_AW];
    assign w_sel       = c_SW'(w_idx);
    assign w_hit       = r_cache_vld && (REQ_ADDR == r_cache_addr);
    // The full index field is compared, so unused encodings report out-of-range.
    assign w_oor       = (32'(w_idx) >= c_NBANK);
    assign w_load      = (r_state == c_IDLE) && REQ_RD && !w_hit && !w_oor;
    assign w_ok        = BANK_OK[r_sel];
    assign w_timeout   = (r_cnt == c_CNT_LAST);
    assign w_bank_data = BANK_DOUT[r_sel*DW +: DW];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (REQ_RD) begin
                    w_next = (w_hit || w_oor) ? c_DONE : c_ISSUE;
                end
            end
            c_ISSUE: w_next = c_WAIT;
            c_WAIT: begin
                if (w_ok || w_timeout) begin
                    w_next = c_DONE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Outputs decode only from registers, so no input reaches an output combinationally.
    always_comb begin
        REQ_VALID = (r_state == c_DONE);
        ERR       = (r_state == c_DONE) && r_err;
        BUSY      = (r_state != c_IDLE);
        BANK_CS   = '0;
        if ((r_state == c_ISSUE) || (r_state == c_WAIT)) begin
            BANK_CS = NBANK'(1) << r_sel;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sel        <= '0;
            r_cnt        <= '0;
            r_req_addr   <= '0;
            r_cache_addr <= '0;
            r_cache_data <= '0;
            r_cache_vld  <= 1'b0;
            r_dout       <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (REQ_RD) begin
                        if (w_hit) begin
                            r_dout <= r_cache_data;
                            r_err  <= 1'b0;
                        end else if (w_oor) begin
                            r_dout <= '0;
                            r_err  <= 1'b1;
                        end else begin
                            r_sel      <= w_sel;
                            r_req_addr <= REQ_ADDR;
                        end
                    end
                end
                c_ISSUE: r_cnt <= '0;
                c_WAIT: begin
                    if (w_ok) begin
                        r_dout       <= w_bank_data;
                        r_err        <= 1'b0;
                        r_cache_addr <= r_req_addr;
                        r_cache_data <= w_bank_data;
                        r_cache_vld  <= 1'b1;
                    end else if (w_timeout) begin
                        r_dout      <= '0;
                        r_err       <= 1'b1;
                        r_cache_vld <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign REQ_DOUT = r_dout;

    // Each bank's address only moves when a miss is issued to it, keeping idle SDRAM slots aligned.
    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic [BANK_AW-1:0] r_bank_addr;

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_bank_addr <= '0;
            end else if (w_load && (w_sel == c_SW'(i))) begin
                r_bank_addr <= REQ_ADDR[BANK_AW-1:0];
            end
        end

        assign BANK_ADDR[i*BANK_AW +: BANK_AW] = r_bank_addr;
    end

endmodule
`default_nettype wire

// File: doc/pcm_bank_router.md
# pcm_bank_router

Parametrised PCM sample-ROM request router for the sound board. It sits between the ADPCM chip's byte-wide ROM read port and N SDRAM sample banks. It replaces fixed three-bank combinational decoding with a registered request/acknowledge state machine, a single-entry last-byte cache, out-of-range handling and a stall timeout. Each bank keeps its last address stable while deselected, so SDRAM slots stay aligned.

## Interface
Parameters:
- NBANK, 3, number of SDRAM sample banks (1..8)
- AW, 24, width of the requester byte address
- BANK_AW, 22, address width of one bank; bank index = REQ_ADDR[AW-1:BANK_AW]
- DW, 8, data width
- TIMEOUT, 255, maximum WAIT cycles before forced completion (≥2)

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- REQ_RD  in  1  read request, level; held until REQ_VALID
- REQ_ADDR  in  AW  byte address, stable while REQ_RD high
- REQ_DOUT  out  DW  returned byte; held between completions
- REQ_VALID  out  1  one-cycle completion pulse
- BUSY  out  1  high in any state other than IDLE
- ERR  out  1  one-cycle pulse on out-of-range or timeout completion
- BANK_CS  out  NBANK  one-hot bank select
- BANK_ADDR  out  NBANK*BANK_AW  per-bank address, slice i for bank i
- BANK_OK  in  NBANK  per-bank data-ready from SDRAM
- BANK_DOUT  in  NBANK*DW  per-bank data, slice i for bank i

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: REQ_RD is sampled only in IDLE.
  - REQ_RD high and cache valid and REQ_ADDR == cached address -> DONE, data = cached byte (hit).
  - Else, if index ≥ NBANK -> DONE, data = 0, ERR flagged, cache unchanged.
  - Else latch address and index, load BANK_ADDR slice[index] with REQ_ADDR[BANK_AW-1:0], -> ISSUE.
- ISSUE: BANK_CS[index] = 1. BANK_OK is ignored in this state, because OK may be stale from the previous address. -> WAIT; the timeout counter clears.
- WAIT: BANK_CS[index] stays 1.
  - BANK_OK[index] = 1 -> capture BANK_DOUT slice, write cache (address + byte, valid = 1), -> DONE.
  - Else the counter increments. When the counter reaches TIMEOUT -> DONE, data = 0, ERR flagged, cache invalidated.
  - OK from other banks is ignored.
- DONE: REQ_VALID = 1, REQ_DOUT updated this cycle, ERR = 1 if flagged; BANK_CS = 0; -> IDLE unconditionally.
- The requester must drop REQ_RD in the REQ_VALID cycle. If REQ_RD is still high in the next IDLE cycle, that is a new request.
- BANK_ADDR slices are only written on entry to ISSUE and otherwise hold their values.
- Reset values: all BANK_ADDR slices 0; REQ_DOUT 0; REQ_VALID, ERR, BUSY, BANK_CS all 0; cache invalid; state IDLE; counter 0.
- Reset asserted mid-transaction: everything returns to its reset value immediately (asynchronous) and no REQ_VALID is issued. The requester must re-request.
- NBANK = 1: the bank index field is still compared, so any address ≥ 2^BANK_AW reports out-of-range.

## Timing
- Miss latency: request seen in IDLE at cycle 0; ISSUE at 1; WAIT from 2. REQ_VALID comes 1 cycle after the first WAIT cycle with OK, so it is 3 cycles minimum when OK is already high at cycle 2.
- Hit latency: REQ_VALID at cycle 1.
- Out-of-range latency: REQ_VALID with ERR at cycle 1.
- Timeout: with OK never asserted, REQ_VALID and ERR come TIMEOUT+2 cycles after request sampling, with REQ_DOUT = 0.
- BANK_CS is high for exactly (ISSUE + WAIT) cycles and is never high in IDLE or DONE. At most one BANK_CS bit is high at any time.
- Back-to-back throughput on misses is one request per 4 cycles minimum (IDLE, ISSUE, WAIT, DONE).
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Miss in bank 1 (NBANK=3): REQ_ADDR=0x400123, BANK_OK[1] high from cycle 2 with data 0x5A -> BANK_CS=3'b010 for cycles 1–2; BANK_ADDR slice1=0x000123; REQ_VALID at cycle 3 with REQ_DOUT=0x5A; ERR=0.
- Stale OK: BANK_OK[0] held high before the request to 0x000010; real data 0x11 arrives when OK rises at WAIT cycle 3 -> the ISSUE-cycle OK is ignored; REQ_DOUT=0x11, REQ_VALID at cycle 4.
- Cache hit: repeat 0x400123 immediately -> REQ_VALID at cycle 1, REQ_DOUT=0x5A, BANK_CS stays 0.
- Out-of-range: REQ_ADDR=0xC00000 -> REQ_VALID and ERR at cycle 1, REQ_DOUT=0x00, no BANK_CS; a following hit on 0x400123 still returns 0x5A.
- Timeout: TIMEOUT=8, bank 2 OK never rises -> REQ_VALID and ERR at cycle 10, REQ_DOUT=0; the next request to 0x400123 misses (cache invalidated).
- Reset mid-WAIT: drop RESET_N during WAIT -> BANK_CS, BUSY and REQ_VALID go to 0 asynchronously, BANK_ADDR slices go to 0, no completion pulse; after release, a fresh request completes normally.
